// File: rtl/pc_sequencer.sv
// Program-counter sequencer.
// Steps a program counter through BOOT -> IDLE -> FETCH -> WAIT -> EXEC, driving the
// counter's load and offset ports, and enters FAULT when memory fails to answer in time.
//
// Parameters:
//   TIMEOUT      - WAIT cycles without mem_ready_i before FAULT (1..255)
//   RESET_VECTOR - address loaded into the program counter at boot
// Ports:
//   clk_i, rst_ni                        - clock, asynchronous active-low reset
//   run_i                                - sequencing enabled while high
//   mem_ready_i                          - fetched instruction available
//   jump_req_i, jump_addr_i, jump_ack_o  - absolute jump request / handshake
//   branch_req_i, branch_offset_i, branch_ack_o - relative branch request / handshake
//   clear_fault_i                        - leaves FAULT towards IDLE
//   load_enable_o, load_value_o          - program counter load port
//   offset_enable_o, offset_o            - program counter offset port
//   fetch_strobe_o                       - one-cycle fetch request
//   instr_count_o                        - retired-instruction count (wraps at 2^16)
//   fault_o, state_o                     - fault flag and current state encoding
module pc_sequencer #(
  parameter int unsigned TIMEOUT      = 15,
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        mem_ready_i,
  input  logic        jump_req_i,
  input  logic [15:0] jump_addr_i,
  output logic        jump_ack_o,
  input  logic        branch_req_i,
  input  logic [8:0]  branch_offset_i,
  output logic        branch_ack_o,
  input  logic        clear_fault_i,
  output logic        load_enable_o,
  output logic [15:0] load_value_o,
  output logic        offset_enable_o,
  output logic [8:0]  offset_o,
  output logic        fetch_strobe_o,
  output logic [15:0] instr_count_o,
  output logic        fault_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StIdle  = 3'd1,
    StFetch = 3'd2,
    StWait  = 3'd3,
    StExec  = 3'd4,
    StFault = 3'd5
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q;
  logic        boot_armed_q;
  logic [7:0]  wait_cnt_q;
  logic [15:0] instr_count_q;

  // Reset parks the FSM in BOOT with every output low. The first edge after release arms
  // BOOT, so the reset-vector load is presented for exactly one full cycle afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StBoot;
      boot_armed_q  <= 1'b0;
      wait_cnt_q    <= 8'd0;
      instr_count_q <= 16'd0;
    end else begin
      case (state_q)
        StBoot: begin
          if (!boot_armed_q) begin
            boot_armed_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (run_i) state_q <= StFetch;
        end
        StFetch: begin
          wait_cnt_q <= 8'd0;
          state_q    <= StWait;
        end
        StWait: begin
          // Ready wins even in the cycle that would otherwise time out.
          if (mem_ready_i) begin
            state_q <= StExec;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            if (wait_cnt_q + 8'd1 == TimeoutCnt) state_q <= StFault;
          end
        end
        StExec: begin
          instr_count_q <= instr_count_q + 16'd1;
          state_q       <= run_i ? StFetch : StIdle;
        end
        StFault: begin
          if (clear_fault_i) state_q <= StIdle;
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  // Outputs decode the registered state; only the EXEC port selection looks at requests.
  always_comb begin
    load_enable_o   = 1'b0;
    load_value_o    = 16'd0;
    offset_enable_o = 1'b0;
    offset_o        = 9'd0;
    jump_ack_o      = 1'b0;
    branch_ack_o    = 1'b0;
    fetch_strobe_o  = 1'b0;
    fault_o         = 1'b0;
    case (state_q)
      StBoot: begin
        if (boot_armed_q) begin
          load_enable_o = 1'b1;
          load_value_o  = RESET_VECTOR;
        end
      end
      StFetch: fetch_strobe_o = 1'b1;
      StExec: begin
        // Jump has priority; an unserved branch stays pending for a later EXEC.
        if (jump_req_i) begin
          load_enable_o = 1'b1;
          load_value_o  = jump_addr_i;
          jump_ack_o    = 1'b1;
        end else if (branch_req_i) begin
          offset_enable_o = 1'b1;
          offset_o        = branch_offset_i;
          branch_ack_o    = 1'b1;
        end else begin
          offset_enable_o = 1'b1;
          offset_o        = 9'd1;
        end
      end
      StFault: fault_o = 1'b1;
      default: ;
    endcase
  end

  assign instr_count_o = instr_count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected program-counter port actions are queued
// by the stimulus side and popped by a monitor whenever the DUT drives a PC port.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic        jump_req = 1'b0;
  logic [15:0] jump_addr = 16'd0;
  logic        jump_ack;
  logic        branch_req = 1'b0;
  logic [8:0]  branch_offset = 9'd0;
  logic        branch_ack;
  logic        clear_fault = 1'b0;
  logic        load_enable;
  logic [15:0] load_value;
  logic        offset_enable;
  logic [8:0]  offset;
  logic        fetch_strobe;
  logic [15:0] instr_count;
  logic        fault;
  logic [2:0]  state;

  pc_sequencer #(
    .TIMEOUT      (15),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .run_i           (run),
    .mem_ready_i     (mem_ready),
    .jump_req_i      (jump_req),
    .jump_addr_i     (jump_addr),
    .jump_ack_o      (jump_ack),
    .branch_req_i    (branch_req),
    .branch_offset_i (branch_offset),
    .branch_ack_o    (branch_ack),
    .clear_fault_i   (clear_fault),
    .load_enable_o   (load_enable),
    .load_value_o    (load_value),
    .offset_enable_o (offset_enable),
    .offset_o        (offset),
    .fetch_strobe_o  (fetch_strobe),
    .instr_count_o   (instr_count),
    .fault_o         (fault),
    .state_o         (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [15:0] value;
    bit          jack;
    bit          back;
    logic [15:0] count;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_count = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected action of one retiring instruction, from the requests the bench is holding.
  task automatic push_instr();
    exp_t e;
    e.count = exp_count;
    e.jack  = 1'b0;
    e.back  = 1'b0;
    if (jump_req) begin
      e.is_load = 1'b1;
      e.value   = jump_addr;
      e.jack    = 1'b1;
    end else if (branch_req) begin
      e.is_load = 1'b0;
      e.value   = {7'd0, branch_offset};
      e.back    = 1'b1;
    end else begin
      e.is_load = 1'b0;
      e.value   = 16'd1;
    end
    sb.push_back(e);
    exp_count = exp_count + 16'd1;
  endtask

  task automatic push_boot();
    exp_t e;
    e.is_load = 1'b1;
    e.value   = 16'h0000;
    e.jack    = 1'b0;
    e.back    = 1'b0;
    e.count   = exp_count;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("enables_exclusive", {31'd0, load_enable & offset_enable}, 32'd0);
        if (!load_enable) chk("load_value_idle", {16'd0, load_value}, 32'd0);
        if (!offset_enable) chk("offset_idle", {23'd0, offset}, 32'd0);
        if (load_enable || offset_enable) begin
          if (sb.size() == 0) begin
            chk("unexpected_pc_update", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("pc_port_load", {31'd0, load_enable}, {31'd0, e.is_load});
            chk("pc_port_value", e.is_load ? {16'd0, load_value} : {23'd0, offset},
                {16'd0, e.value});
            chk("jump_ack", {31'd0, jump_ack}, {31'd0, e.jack});
            chk("branch_ack", {31'd0, branch_ack}, {31'd0, e.back});
            chk("count_at_exec", {16'd0, instr_count}, {16'd0, e.count});
          end
        end
      end
    end
  endtask

  // Waits for the next EXEC (bounded); optionally drops Run during it, optionally
  // randomises mem_ready with at most four consecutive misses. Returns at posedge+1.
  task automatic exec_one(input bit stop, input bit rnd_ready, output time stamp);
    int misses = 0;
    bit seen = 1'b0;
    stamp = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (state == 3'd4) begin
        seen  = 1'b1;
        stamp = $time;
        if (stop) run = 1'b0;
      end else if (rnd_ready) begin
        if (misses >= 4 || $urandom_range(0, 2) != 0) begin
          mem_ready = 1'b1;
          misses = 0;
        end else begin
          mem_ready = 1'b0;
          misses++;
        end
      end
    end
    chk("exec_reached", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, {29'd0, state}, 32'd0);
    chk({tag, "_count"}, {16'd0, instr_count}, 32'd0);
    chk({tag, "_outs"}, {24'd0, fault, fetch_strobe, load_enable, offset_enable, jump_ack,
        branch_ack, |load_value, |offset}, 32'd0);
  endtask

  initial begin
    time t0, t1;
    int  nwait;
    bit  flag;
    fork
      monitor();
    join_none

    // Reset held across clock edges with busy inputs.
    run = 1'b1; mem_ready = 1'b1; jump_req = 1'b1; jump_addr = 16'hBEEF;
    repeat (3) @(posedge clk);
    #3;
    chk_all_zero("reset");
    jump_req = 1'b0;

    // Boot then four sequential instructions, one every three cycles.
    push_boot();
    for (int i = 0; i < 4; i++) push_instr();
    rst_n = 1'b1;
    exec_one(1'b0, 1'b0, t0);
    for (int i = 1; i < 4; i++) begin
      exec_one(i == 3, 1'b0, t1);
      chk("exec_period", 32'(t1 - t0), 32'd30);
      t0 = t1;
    end
    chk("idle_after_stop", {29'd0, state}, 32'd1);
    chk("count_after_4", {16'd0, instr_count}, 32'd4);

    // Jump and branch together: jump first, branch on the next EXEC.
    jump_req = 1'b1; jump_addr = 16'h1234; branch_req = 1'b1; branch_offset = 9'h1FD;
    run = 1'b1;
    push_instr();
    exec_one(1'b0, 1'b0, t0);
    jump_req = 1'b0;
    push_instr();
    exec_one(1'b1, 1'b0, t0);
    branch_req = 1'b0;
    chk("count_after_branch", {16'd0, instr_count}, 32'd6);

    // Memory never answers: FAULT after exactly 15 WAIT cycles.
    mem_ready = 1'b0; run = 1'b1; nwait = 0; flag = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (state == 3'd5) break;
      if (fault) flag = 1'b1;
      if (state == 3'd3) nwait++;
    end
    run = 1'b0;
    chk("timeout_wait_cycles", nwait, 32'd15);
    chk("fault_early", {31'd0, flag}, 32'd0);
    chk("fault_state", {29'd0, state}, 32'd5);
    chk("fault_flag", {31'd0, fault}, 32'd1);
    chk("fault_quiet", {30'd0, fetch_strobe, load_enable | offset_enable}, 32'd0);
    @(posedge clk); #1;
    clear_fault = 1'b1;
    @(posedge clk); #1;
    clear_fault = 1'b0;
    chk("cleared_state", {29'd0, state}, 32'd1);
    chk("cleared_fault", {31'd0, fault}, 32'd0);
    chk("cleared_count", {16'd0, instr_count}, 32'd6);

    // Ready arrives in the timeout cycle itself: ready wins.
    run = 1'b1; nwait = 0; flag = 1'b0;
    push_instr();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (fault) flag = 1'b1;
      if (state == 3'd4) begin
        run = 1'b0;
        break;
      end
      if (state == 3'd3) begin
        nwait++;
        if (nwait == 15) mem_ready = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("late_ready_waits", nwait, 32'd15);
    chk("late_ready_no_fault", {31'd0, flag | fault}, 32'd0);
    chk("late_ready_idle", {29'd0, state}, 32'd1);

    // Run dropped during FETCH: instruction still completes, then IDLE.
    run = 1'b1; mem_ready = 1'b1;
    push_instr();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (state == 3'd2) begin
        run = 1'b0;
        break;
      end
    end
    exec_one(1'b0, 1'b0, t0);
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (state != 3'd1 || fetch_strobe) flag = 1'b1;
    end
    chk("run_drop_idle", {31'd0, flag}, 32'd0);
    chk("run_drop_count", {16'd0, instr_count}, 32'd8);

    // Random requests and memory latency.
    @(posedge clk); #1;
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!jump_req && $urandom_range(0, 2) == 0) begin
        jump_req  = 1'b1;
        jump_addr = 16'($urandom);
      end
      if (!branch_req && $urandom_range(0, 2) == 0) begin
        branch_req    = 1'b1;
        branch_offset = 9'($urandom);
      end
      push_instr();
      exec_one(i == 39, 1'b1, t0);
      if (jump_req) jump_req = 1'b0;
      else if (branch_req) branch_req = 1'b0;
    end
    jump_req = 1'b0; branch_req = 1'b0; mem_ready = 1'b1;
    chk("random_count", {16'd0, instr_count}, {16'd0, exp_count});

    // Count wrap: preload near the top instead of retiring 65535 instructions.
    dut.instr_count_q = 16'hFFFD;
    exp_count = 16'hFFFD;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_instr();
      exec_one(i == 3, 1'b0, t0);
    end
    chk("wrap_count", {16'd0, instr_count}, 32'd1);

    // Asynchronous reset in the middle of WAIT, with a jump pending.
    run = 1'b1; mem_ready = 1'b0; jump_req = 1'b1; jump_addr = 16'h5A5A;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (state == 3'd3) break;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    sb.delete();
    exp_count = 16'd0;
    jump_req = 1'b0; run = 1'b0;
    push_boot();
    @(posedge clk); #1;
    rst_n = 1'b1;
    flag = 1'b0;
    for (int c = 0; c < 10 && !flag; c++) begin
      @(negedge clk);
      if (load_enable && state == 3'd0) flag = 1'b1;
    end
    chk("reboot_load", {31'd0, flag}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("reboot_idle", {29'd0, state}, 32'd1);
    chk("reboot_count", {16'd0, instr_count}, 32'd0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning max WAIT cycles without MemReady before FAULT; legal 1..255.
REQ-002 Parameter RESET_VECTOR, default 16'h0000, meaning address loaded into the program counter at boot.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Run  input  1  level; sequencing enabled while high.
REQ-006 MemReady  input  1  fetched instruction available.
REQ-007 JumpReq  input  1; JumpAddr  input  16  absolute target; JumpAck  output  1.
REQ-008 BranchReq  input  1; BranchOffset  input  9  two's-complement; BranchAck  output  1.
REQ-009 ClearFault  input  1  exits FAULT.
REQ-010 LoadEnable  output  1; LoadValue  output  16  drive the program counter load port.
REQ-011 OffsetEnable  output  1; Offset  output  9  drive the program counter offset port.
REQ-012 FetchStrobe  output  1  one-cycle fetch request.
REQ-013 InstrCount  output  16  retired-instruction count, for the five-digit decimal display.
REQ-014 Fault  output  1; State  output  3  current FSM state encoding.

Function
REQ-015 The FSM SHALL have states BOOT=0, IDLE=1, FETCH=2, WAIT=3, EXEC=4, FAULT=5, with State equal to the current encoding.
REQ-016 BOOT: LoadEnable=1, LoadValue=RESET_VECTOR for exactly one cycle; next state IDLE unconditionally.
REQ-017 IDLE: no enables asserted; Run=1 -> FETCH on next edge, else remain.
REQ-018 FETCH: FetchStrobe=1 for exactly that cycle; wait counter cleared to 0; next state WAIT.
REQ-019 WAIT: MemReady=1 -> EXEC; else counter increments; counter==TIMEOUT with MemReady=0 -> FAULT; MemReady=1 in the timeout cycle -> EXEC (ready wins).
REQ-020 EXEC (one cycle): JumpReq=1 -> LoadEnable=1, LoadValue=JumpAddr, JumpAck=1.
REQ-021 EXEC: JumpReq=0, BranchReq=1 -> OffsetEnable=1, Offset=BranchOffset, BranchAck=1.
REQ-022 EXEC: neither request -> OffsetEnable=1, Offset=9'd1 (sequential increment).
REQ-023 Both requests in EXEC: jump wins; BranchAck=0; branch stays pending for a later EXEC.
REQ-024 Requesters hold Req and data stable until Ack; Ack is combinational, only in EXEC, one cycle per instruction.
REQ-025 EXEC increments InstrCount by 1 modulo 2^16 (16'hFFFF -> 16'h0000); next state FETCH if Run=1, else IDLE.
REQ-026 Run falling in FETCH/WAIT SHALL NOT abort; the instruction completes through EXEC, then IDLE.
REQ-027 LoadEnable and OffsetEnable SHALL never be high in the same cycle; LoadValue=0 and Offset=0 whenever their enable is low.
REQ-028 FAULT: Fault=1, no enables, no acks, FetchStrobe=0; ClearFault=1 -> IDLE with InstrCount preserved.
REQ-029 Outputs other than Ack/enable data in EXEC SHALL be decoded from registered state only.

Reset
REQ-030 Reset=0 SHALL immediately force state BOOT, InstrCount=0, wait counter=0, Fault=0 and all other outputs 0 except State=0, regardless of clock.
REQ-031 On the first rising edge after Reset rises, BOOT outputs (REQ-016) are active; assertion mid-operation discards any in-flight instruction and pending acks.

Verification
REQ-032 Reset release, Run=1, MemReady tied 1 -> BOOT load 16'h0000, then FETCH/WAIT/EXEC every 3 cycles with Offset=1; InstrCount=4 after 4 EXECs.
REQ-033 JumpReq=1, JumpAddr=16'h1234, BranchReq=1, BranchOffset=-3 held -> first EXEC: LoadValue=16'h1234, JumpAck; drop JumpReq -> next EXEC: Offset=9'h1FD, BranchAck.
REQ-034 MemReady=0 with TIMEOUT=15 -> FAULT after 15 WAIT cycles, Fault=1; ClearFault pulse -> IDLE, InstrCount unchanged.
REQ-035 MemReady rises in the exact timeout cycle -> EXEC, Fault stays 0.
REQ-036 Preload InstrCount to 16'hFFFF via 65535 EXECs -> next EXEC gives 16'h0000; Reset=0 during WAIT -> all outputs 0 asynchronously, BOOT reload afterwards.
